// File: rtl/regfield_spi_frontend.sv
// SPI mode-0 slave front-end producing single-cycle read/write strobes for the register field.
// Optional burst mode (auto-incrementing address): define REGFIELD_CMD_AUTOINC_EN.
module regfield_spi_frontend #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sck_sync_q;
  logic [1:0]        cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              sck_rise, sck_fall, cs_act;
  logic              cs_act_q, rise_q, fall_q, mosi_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_byte;
  logic              is_wr_q, is_wr_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              capture_q;
`ifdef REGFIELD_CMD_AUTOINC_EN
  logic              inc_pend_q, inc_pend_d;
  logic              re_pend_q, re_pend_d;
`endif

  // Edge pulses and the matching MOSI sample are registered once more so strobes land 3 clk after sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_act_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      rise_q      <= sck_rise;
      fall_q      <= sck_fall;
      mosi_q      <= mosi_sync_q[1];
      cs_act_q    <= cs_act;
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_act   = ~cs_sync_q[1] & ena;
  assign rx_byte  = {rx_q[6:0], mosi_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    is_wr_d = is_wr_q;
    miso_d  = miso_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
`ifdef REGFIELD_CMD_AUTOINC_EN
    inc_pend_d = 1'b0;
    re_pend_d  = 1'b0;
    if (inc_pend_q) begin
      addr_d = addr_q + 1'b1;
    end
    if (re_pend_q) begin
      re_d = 1'b1;
    end
`endif
    if (capture_q) begin
      tx_d = reg_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        rx_d    = '0;
        tx_d    = '0;
        miso_d  = 1'b0;
        is_wr_d = 1'b0;
        if (cs_act && !cs_act_q) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (rise_q) begin
          rx_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_d  = rx_byte[ADDR_W-1:0];
            is_wr_d = rx_byte[7];
            re_d    = ~rx_byte[7];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rise_q) begin
          rx_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (is_wr_q) begin
              wdata_d = rx_byte;
              we_d    = 1'b1;
            end
`ifdef REGFIELD_CMD_AUTOINC_EN
            // Writes bump the address after the strobe; reads bump first so the next byte is fetched in time.
            if (is_wr_q) begin
              inc_pend_d = 1'b1;
            end else begin
              addr_d    = addr_q + 1'b1;
              re_pend_d = 1'b1;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
        if (fall_q && !is_wr_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Losing chip select drops any partial byte without issuing a strobe.
    if (state_q != ST_IDLE && !cs_act) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      re_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef REGFIELD_CMD_AUTOINC_EN
      inc_pend_d = 1'b0;
      re_pend_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      is_wr_q   <= 1'b0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      is_wr_q   <= is_wr_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      capture_q <= re_q;
    end
  end

`ifdef REGFIELD_CMD_AUTOINC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_pend_q <= 1'b0;
      re_pend_q  <= 1'b0;
    end else begin
      inc_pend_q <= inc_pend_d;
      re_pend_q  <= re_pend_d;
    end
  end
`endif

  assign busy        = (state_q != ST_IDLE);
  assign spi_miso_oe = (state_q != ST_IDLE);
  assign spi_miso    = miso_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;

endmodule

// File: tb/tb_regfield_spi_frontend.sv
// Directed self-checking bench for regfield_spi_frontend (ADDR_W = 4, SCK phases of 6 clk).
module tb_regfield_spi_frontend;

  localparam int HALF = 6;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'hFF;
  logic       busy;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;
  int weCount = 0;
  int reCount = 0;
  int bothCount = 0;
  int oeCount = 0;
  int lastRiseEdge = 0;
  int weAddrLog [0:7];
  int weDataLog [0:7];
  int weCycleLog [0:7];
  int reAddrLog [0:7];
  int reCycleLog [0:7];
  logic [7:0] regMem [0:15];

  regfield_spi_frontend #(.ADDR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt++;

  // Register-field model: registered read, data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= regMem[reg_addr];
  end

  always @(negedge clk) begin
    if (reg_we) begin
      weAddrLog[weCount % 8]  = int'(reg_addr);
      weDataLog[weCount % 8]  = int'(reg_wdata);
      weCycleLog[weCount % 8] = cycleCnt;
      weCount++;
    end
    if (reg_re) begin
      reAddrLog[reCount % 8]  = int'(reg_addr);
      reCycleLog[reCount % 8] = cycleCnt;
      reCount++;
    end
    if (reg_we && reg_re) bothCount++;
    if (spi_miso_oe) oeCount++;
  end

  task automatic csBegin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic csEnd();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spiXfer(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
    rxByte = 8'h00;
    for (int i = 7; i > 7 - nBits; i--) begin
      spi_mosi = txByte[i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      lastRiseEdge = cycleCnt + 1;
      rxByte[i] = spi_miso;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    testsRun++; if (spi_miso !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
    testsRun++; if (spi_miso_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_oe: got %b expected 0", spi_miso_oe); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++; if (reg_addr !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", reg_addr); end
    testsRun++; if (reg_wdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_wdata: got %h expected 00", reg_wdata); end
    testsRun++; if (reg_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %b expected 0", reg_we); end
    testsRun++; if (reg_re !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_re: got %b expected 0", reg_re); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int weBase, reBase, riseEdge;
    logic [7:0] r0, r1;
    weBase = weCount;
    reBase = reCount;
    csBegin();
    spiXfer(8'h85, 8, r0);
    testsRun++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin testsFailed++; $display("[TB] FAIL write_busy_oe: got busy=%b oe=%b expected 1/1", busy, spi_miso_oe); end
    spiXfer(8'h3C, 8, r1);
    riseEdge = lastRiseEdge;
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL write_busy_hold: got %b expected 1", busy); end
    @(posedge clk);
    #1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_busy_fall: got %b expected 0", busy); end
    repeat (8) @(negedge clk);
    testsRun++; if (weCount - weBase !== 1) begin testsFailed++; $display("[TB] FAIL write_we_count: got %0d expected 1", weCount - weBase); end
    testsRun++; if (weAddrLog[weBase % 8] !== 5) begin testsFailed++; $display("[TB] FAIL write_addr: got %0h expected 5", weAddrLog[weBase % 8]); end
    testsRun++; if (weDataLog[weBase % 8] !== 8'h3C) begin testsFailed++; $display("[TB] FAIL write_data: got %0h expected 3c", weDataLog[weBase % 8]); end
    testsRun++; if (weCycleLog[weBase % 8] - riseEdge !== 3) begin testsFailed++; $display("[TB] FAIL write_latency: got %0d expected 3", weCycleLog[weBase % 8] - riseEdge); end
    testsRun++; if (reCount - reBase !== 0) begin testsFailed++; $display("[TB] FAIL write_no_re: got %0d expected 0", reCount - reBase); end
    testsRun++; if (r0 !== 8'h00 || r1 !== 8'h00) begin testsFailed++; $display("[TB] FAIL write_miso: got %h %h expected 00 00", r0, r1); end
  endtask

  task automatic test_read();
    int weBase, reBase, cmdRise;
    logic [7:0] r0, r1;
    weBase = weCount;
    reBase = reCount;
    csBegin();
    spiXfer(8'h02, 8, r0);
    cmdRise = lastRiseEdge;
    spiXfer(8'h00, 8, r1);
    csEnd();
`ifdef REGFIELD_CMD_AUTOINC_EN
    testsRun++; if (reCount - reBase !== 2) begin testsFailed++; $display("[TB] FAIL read_re_count: got %0d expected 2", reCount - reBase); end
`else
    testsRun++; if (reCount - reBase !== 1) begin testsFailed++; $display("[TB] FAIL read_re_count: got %0d expected 1", reCount - reBase); end
`endif
    testsRun++; if (reAddrLog[reBase % 8] !== 2) begin testsFailed++; $display("[TB] FAIL read_addr: got %0h expected 2", reAddrLog[reBase % 8]); end
    testsRun++; if (reCycleLog[reBase % 8] - cmdRise !== 3) begin testsFailed++; $display("[TB] FAIL read_latency: got %0d expected 3", reCycleLog[reBase % 8] - cmdRise); end
    testsRun++; if (r0 !== 8'h00) begin testsFailed++; $display("[TB] FAIL read_first_byte: got %h expected 00", r0); end
    testsRun++; if (r1 !== 8'hA5) begin testsFailed++; $display("[TB] FAIL read_data_byte: got %h expected a5", r1); end
    testsRun++; if (weCount - weBase !== 0) begin testsFailed++; $display("[TB] FAIL read_no_we: got %0d expected 0", weCount - weBase); end
  endtask

  task automatic test_burst_write();
    int weBase;
    logic [7:0] r;
    weBase = weCount;
    csBegin();
    spiXfer(8'h8F, 8, r);
    spiXfer(8'h11, 8, r);
    spiXfer(8'h22, 8, r);
    csEnd();
    testsRun++; if (weAddrLog[weBase % 8] !== 15 || weDataLog[weBase % 8] !== 8'h11) begin testsFailed++; $display("[TB] FAIL burst_first: got addr=%0h data=%0h expected f/11", weAddrLog[weBase % 8], weDataLog[weBase % 8]); end
`ifdef REGFIELD_CMD_AUTOINC_EN
    testsRun++; if (weCount - weBase !== 2) begin testsFailed++; $display("[TB] FAIL burst_count: got %0d expected 2", weCount - weBase); end
    testsRun++; if (weAddrLog[(weBase + 1) % 8] !== 0 || weDataLog[(weBase + 1) % 8] !== 8'h22) begin testsFailed++; $display("[TB] FAIL burst_wrap: got addr=%0h data=%0h expected 0/22", weAddrLog[(weBase + 1) % 8], weDataLog[(weBase + 1) % 8]); end
`else
    testsRun++; if (weCount - weBase !== 1) begin testsFailed++; $display("[TB] FAIL burst_count: got %0d expected 1", weCount - weBase); end
    testsRun++; if (reg_addr !== 4'hF || reg_wdata !== 8'h11) begin testsFailed++; $display("[TB] FAIL burst_hold: got addr=%h data=%h expected f/11", reg_addr, reg_wdata); end
`endif
  endtask

  task automatic test_abort();
    int weBase;
    logic [7:0] r;
    weBase = weCount;
    csBegin();
    spiXfer(8'h83, 8, r);
    spiXfer(8'hFF, 5, r);
    csEnd();
    testsRun++; if (weCount - weBase !== 0) begin testsFailed++; $display("[TB] FAIL abort_no_we: got %0d expected 0", weCount - weBase); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_idle: got busy=%b expected 0", busy); end
    csBegin();
    spiXfer(8'h83, 8, r);
    spiXfer(8'h7E, 8, r);
    csEnd();
    testsRun++; if (weCount - weBase !== 1) begin testsFailed++; $display("[TB] FAIL abort_next_count: got %0d expected 1", weCount - weBase); end
    testsRun++; if (weAddrLog[weBase % 8] !== 3 || weDataLog[weBase % 8] !== 8'h7E) begin testsFailed++; $display("[TB] FAIL abort_next_write: got addr=%0h data=%0h expected 3/7e", weAddrLog[weBase % 8], weDataLog[weBase % 8]); end
  endtask

  task automatic test_reset_midframe();
    int weBase, reBase;
    logic [7:0] r;
    weBase = weCount;
    reBase = reCount;
    csBegin();
    spiXfer(8'h84, 8, r);
    spiXfer(8'hFF, 4, r);
    rst_n = 1'b0;
    #1;
    testsRun++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_busy_oe: got busy=%b oe=%b expected 0/0", busy, spi_miso_oe); end
    testsRun++; if (reg_addr !== 4'h0) begin testsFailed++; $display("[TB] FAIL midreset_addr: got %h expected 0", reg_addr); end
    testsRun++; if (reg_wdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL midreset_wdata: got %h expected 00", reg_wdata); end
    testsRun++; if (spi_miso !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_strobes: got miso=%b we=%b re=%b expected 0/0/0", spi_miso, reg_we, reg_re); end
    spiXfer(8'h0F, 4, r);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    testsRun++; if (weCount - weBase !== 0 || reCount - reBase !== 0) begin testsFailed++; $display("[TB] FAIL midreset_no_strobe: got we=%0d re=%0d expected 0/0", weCount - weBase, reCount - reBase); end
    csBegin();
    spiXfer(8'h86, 8, r);
    spiXfer(8'h5A, 8, r);
    csEnd();
    testsRun++; if (weCount - weBase !== 1) begin testsFailed++; $display("[TB] FAIL midreset_next_count: got %0d expected 1", weCount - weBase); end
    testsRun++; if (weAddrLog[weBase % 8] !== 6 || weDataLog[weBase % 8] !== 8'h5A) begin testsFailed++; $display("[TB] FAIL midreset_next_write: got addr=%0h data=%0h expected 6/5a", weAddrLog[weBase % 8], weDataLog[weBase % 8]); end
  endtask

  task automatic test_ena_low();
    int weBase, reBase, oeBase;
    logic [7:0] r;
    weBase = weCount;
    reBase = reCount;
    oeBase = oeCount;
    @(negedge clk);
    ena = 1'b0;
    csBegin();
    spiXfer(8'h81, 8, r);
    spiXfer(8'h99, 8, r);
    csEnd();
    spiXfer(8'h02, 8, r);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    testsRun++; if (weCount - weBase !== 0 || reCount - reBase !== 0) begin testsFailed++; $display("[TB] FAIL ena_no_strobe: got we=%0d re=%0d expected 0/0", weCount - weBase, reCount - reBase); end
    testsRun++; if (oeCount - oeBase !== 0) begin testsFailed++; $display("[TB] FAIL ena_oe: got %0d oe cycles expected 0", oeCount - oeBase); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regMem[i] = 8'hC3;
    regMem[2] = 8'hA5;
    ena = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_burst_write();
    test_abort();
    test_reset_midframe();
    test_ena_low();
    testsRun++; if (bothCount !== 0) begin testsFailed++; $display("[TB] FAIL we_re_overlap: got %0d cycles expected 0", bothCount); end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfield_spi_frontend.md
# regfield_spi_frontend

SPI-mode-0 slave front-end that turns byte-framed serial commands into single-cycle read/write strobes for the register-field core (`tt_um_regfield`). It sits directly upstream of the register field. The SPI pins are oversampled by the system clock through synchronizers. The block assembles command and data bytes, drives the register field's address, write-data and strobe lines, and shifts read data back on MISO.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low, ports `clk` and `rst_n`.
- `ADDR_W`, default 4: register address width, legal range 1..7.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design enable; low is treated exactly as `spi_cs_n` high.
- `spi_sck`  in  1  SPI clock, asynchronous to `clk`.
- `spi_cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `spi_miso_oe`  out  1  MISO output enable; high while a frame is active.
- `reg_addr`  out  ADDR_W  register address presented to the register field.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  write strobe, one `clk` wide.
- `reg_re`  out  1  read strobe, one `clk` wide.
- `reg_rdata`  in  8  read data; valid from the `clk` after `reg_re`.
- `busy`  out  1  frame in progress.

## Operation
**Input sampling**
- `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer.
- `spi_sck` has a third flop for edge detection, giving `sck_rise` and `sck_fall`.
- `cs_act` = synchronized `spi_cs_n` low AND `ena` high.

**Command byte**
- Bit 7 = 1 means write, 0 means read.
- Bits [ADDR_W-1:0] = address. Remaining bits are ignored.

**State machine**
- IDLE:
  - Go to CMD on `cs_act` rising.
  - Clear the bit counter (3 bits) and the shift registers.
- CMD:
  - On each `sck_rise`, shift `spi_mosi` in and increment the bit counter.
  - On the 8th bit: load `reg_addr` from the command and go to DATA.
  - For a read command, also pulse `reg_re`.
- DATA, write:
  - On the 8th `sck_rise` of a byte, load `reg_wdata` and pulse `reg_we`.
- DATA, read:
  - Capture `reg_rdata` into the TX shift register the cycle after `reg_re`.
  - On the next `sck_fall` (the 8th falling edge of the preceding byte), drive `spi_miso` = bit 7.
  - Each following `sck_fall` shifts out the next bit.
- After a data byte:
  - With `REGFIELD_CMD_AUTOINC_EN` defined: stay in DATA (see Configuration).
  - Without it: go to DONE.
- DONE:
  - Ignore SCK.
  - `spi_miso` = 0.
  - No strobes.
- Any state except IDLE: `cs_act` low returns to IDLE on the next `clk`.
  - A partial byte is discarded.
  - No strobe is issued for it.

**Other output rules**
- `busy` and `spi_miso_oe` are high in every state except IDLE.
- `spi_miso` = 0 whenever no read data is being shifted, including the whole CMD phase.
- `reg_we` and `reg_re` are never high in the same cycle.

## Timing
- Reset values:
  - `spi_miso` = 0, `spi_miso_oe` = 0, `busy` = 0.
  - `reg_addr` = 0, `reg_wdata` = 0.
  - `reg_we` = 0, `reg_re` = 0.
  - State = IDLE, counters = 0.
- Strobe latency: `reg_we`/`reg_re` goes high exactly 3 `clk` after the first `clk` edge that samples the relevant `spi_sck` rising edge. It stays high for exactly one `clk`.
- `reg_addr` and `reg_wdata` are stable from the strobe cycle until the next strobe.
- MISO latency: `spi_miso` changes 3 `clk` after the sampled `spi_sck` falling edge.
- SCK constraint: the SCK high and low phases must each be ≥ 4 `clk` periods. At this limit, read data is always loaded before the 8th falling edge.
- CS setup/hold:
  - ≥ 4 `clk` from `spi_cs_n` falling to the first SCK rise.
  - ≥ 4 `clk` from the last SCK fall to `spi_cs_n` rising.
  - ≥ 4 `clk` of CS high between frames.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). The frame is lost. A new frame is accepted after `rst_n` deasserts and `cs_act` rises.

## Configuration
- Macro: `REGFIELD_CMD_AUTOINC_EN`.
- Defined (burst mode):
  - After each data byte, `reg_addr` increments and wraps modulo 2^ADDR_W.
  - The FSM stays in DATA.
  - Write: each further byte pulses `reg_we` at the new address.
  - Read: `reg_re` pulses at the incremented address one `clk` after the increment, so bytes stream back continuously.
- Undefined:
  - Exactly one data byte per frame.
  - Further bytes are ignored (DONE state).
  - No incrementer is built.

## Test plan
- Write frame `0x85, 0x3C`, ADDR_W = 4:
  - Exactly one `reg_we` pulse, with `reg_addr` = 5 and `reg_wdata` = 0x3C.
  - No `reg_re` pulse.
  - `busy` falls 1 `clk` after CS-high is synchronized.
- Read frame `0x02, 0x00` with `reg_rdata` = 0xA5 one cycle after `reg_re`:
  - One `reg_re` pulse with `reg_addr` = 2.
  - The master samples 0xA5 in the second byte.
  - The first byte on MISO reads 0x00.
- Burst write `0x8F, 0x11, 0x22`:
  - With the macro: `reg_we` at address 15 with 0x11, then at address 0 with 0x22 (wrap).
  - Without the macro: only the first `reg_we`; `reg_addr` stays 15.
- Abort: command `0x83`, then CS deasserted after 5 data bits:
  - No `reg_we`.
  - The FSM returns to IDLE.
  - A following full write frame `0x83, 0x7E` writes 0x7E to address 3.
- Reset mid-frame: assert `rst_n` low during the data byte of a write:
  - All outputs read their reset values in the same cycle.
  - No strobe is issued.
  - The next frame works normally.
- `ena` low for a whole frame:
  - No strobes.
  - `spi_miso_oe` stays 0.
